// File: rtl/input_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : input_event_queue
// Brief    : Debounced push-button event FIFO, drained by processor loads.
// Revision : 1.0
// ============================================================================
module input_event_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [15:0] DEBOUNCE  = 16'd50000,
    parameter logic [11:0] EVT_ADDR  = 12'hFF0,
    parameter logic [11:0] STAT_ADDR = 12'hFF1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  btn,
    input  logic [11:0] address_dmem,
    input  logic        rden,
    input  logic        wren,
    output logic [31:0] q_evt,
    output logic        hit
);

    localparam int unsigned     c_aw       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     c_cw       = c_aw + 1;
    localparam logic [15:0]     c_deb_last = DEBOUNCE - 16'd1;
    localparam logic [c_cw-1:0] c_full     = c_cw'(DEPTH);

    logic [3:0] w_rise;

    // Per-button 2-flop synchronizer and debounce counter.
    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic        r_meta;
        logic        r_sync;
        logic        r_acc;
        logic [15:0] r_cnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
                r_acc  <= 1'b0;
                r_cnt  <= 16'd0;
            end else begin
                r_meta <= btn[i];
                r_sync <= r_meta;
                if (r_sync == r_acc) begin
                    r_cnt <= 16'd0;
                end else if (r_cnt == c_deb_last) begin
                    r_acc <= r_sync;
                    r_cnt <= 16'd0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end

        assign w_rise[i] = (r_sync != r_acc) && (r_cnt == c_deb_last) && r_sync;
    end

    logic [3:0]      r_pending;
    logic [3:0]      w_grant;
    logic [2:0]      w_code;
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_cw-1:0] r_count;
    logic            r_ovf;
    logic [31:0]     r_q_evt;
    logic            r_hit;
    logic [2:0]      r_mem [DEPTH];

    assign w_grant = r_pending & (~r_pending + 4'd1);

    always_comb begin
        w_code = 3'd0;
        if (r_pending[0])      w_code = 3'd1;
        else if (r_pending[1]) w_code = 3'd2;
        else if (r_pending[2]) w_code = 3'd3;
        else if (r_pending[3]) w_code = 3'd4;
    end

    logic w_sel_evt;
    logic w_sel_stat;
    logic w_load_evt;
    logic w_load_stat;
    logic w_flush;
    logic w_stat_clr;
    logic w_empty;
    logic w_full;
    logic w_push_req;
    logic w_push;
    logic w_overflow;
    logic w_pop;

    assign w_sel_evt   = (address_dmem == EVT_ADDR);
    assign w_sel_stat  = (address_dmem == STAT_ADDR);
    assign w_load_evt  = rden && w_sel_evt;
    assign w_load_stat = rden && w_sel_stat;
    assign w_flush     = wren && w_sel_evt;
    assign w_stat_clr  = wren && w_sel_stat;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_full);
    assign w_push_req  = |r_pending;
    // A flush swallows the arbitrated event without counting it as an overflow.
    assign w_push      = w_push_req && !w_full && !w_flush;
    assign w_overflow  = w_push_req && w_full && !w_flush;
    assign w_pop       = w_load_evt && !w_empty && !w_flush;

    logic [7:0]  w_count8;
    logic [31:0] w_status;
    assign w_count8 = {{(8 - c_cw){1'b0}}, r_count};
    assign w_status = {16'd0, r_ovf, 7'd0, w_count8};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_code;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= 4'd0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_q_evt   <= 32'd0;
            r_hit     <= 1'b0;
        end else begin
            // A press landing on an already-pending bit merges into it.
            r_pending <= (r_pending & ~w_grant) | w_rise;

            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
            end

            if (w_overflow) begin
                r_ovf <= 1'b1;
            end else if (w_load_stat || w_stat_clr) begin
                r_ovf <= 1'b0;
            end

            if (w_load_evt) begin
                r_q_evt <= w_empty ? 32'd0 : {29'd0, r_mem[r_rptr]};
            end else if (w_load_stat) begin
                r_q_evt <= w_status;
            end

            r_hit <= w_load_evt || w_load_stat;
        end
    end

    assign q_evt = r_q_evt;
    assign hit   = r_hit;

endmodule
`default_nettype wire

// File: doc/input_event_queue.md
# input_event_queue

Memory-mapped input peripheral for the Tetris processor. It synchronizes and debounces four raw push-buttons (left, right, rotate, drop) and turns each debounced press into an event code in a small FIFO. The processor drains the FIFO with ordinary `lw` instructions in its data-memory address space, so this block is the input-side counterpart to the processor's memory stage. It sits beside dmem in `skeleton`, and its read data is muxed onto the load path when `hit` is high.

## Interface
- `DEPTH`, 8, FIFO entries (power of two, 2..16)
- `DEBOUNCE`, 16'd50000, cycles a synchronized button must hold a new level before it is accepted (≥1)
- `EVT_ADDR`, 12'hFF0, dmem word address of the event/pop register
- `STAT_ADDR`, 12'hFF1, dmem word address of the status register
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `btn`  in  4  raw asynchronous buttons, active-high; [0]=left, [1]=right, [2]=rotate, [3]=drop
- `address_dmem`  in  12  processor memory-stage word address
- `rden`  in  1  one-cycle load strobe from the memory stage
- `wren`  in  1  one-cycle store strobe from the memory stage
- `q_evt`  out  32  registered read data
- `hit`  out  1  registered; high when `q_evt` is valid for the load issued the previous cycle

## Operation
- Input path, per button: a 2-flop synchronizer feeds a debounce counter.
  - The counter resets whenever the synchronized level equals the accepted level.
  - When it reaches `DEBOUNCE-1` with the levels still differing, the accepted level flips.
  - A 0→1 flip of the accepted level sets that button's `pending` bit. Releases generate nothing.
- Push arbiter: each cycle, the lowest-index set `pending` bit is cleared.
  - If the FIFO is not full, code (index+1), i.e. 1..4, is pushed.
  - If the FIFO is full, the event is dropped and sticky `ovf` is set.
  - At most one push per cycle. A button re-pressed while its pending bit is still set merges into the existing pending bit.
- FIFO: `DEPTH` entries × 3 bits, with read/write pointers wrapping modulo `DEPTH` and `count` of width log2(DEPTH)+1.
- Load from `EVT_ADDR` (`rden`=1): `q_evt` gets {29'b0, head code} and the FIFO pops.
  - If the FIFO is empty, `q_evt`=0 and nothing pops.
- Load from `STAT_ADDR`: `q_evt` = {16'b0, ovf, 7'b0, 3'b0, count}, padded so the low byte holds `count`, with `ovf` at bit 15.
  - The load clears `ovf`.
  - If an overflow occurs in the same cycle as this load, `ovf` ends up 1.
- Store to `EVT_ADDR` (`wren`=1, data ignored): flushes the FIFO (pointers and count to 0). Pending bits are not cleared.
- Store to `STAT_ADDR`: clears `ovf`.
- `hit` = registered (`rden` and address ∈ {`EVT_ADDR`, `STAT_ADDR`}).
- Accesses to other addresses: `hit`=0 and `q_evt` holds its previous value.
- Simultaneous push and pop:
  - Non-empty FIFO: both occur and `count` is unchanged.
  - Empty FIFO: the pop returns 0, the push lands, and `count` becomes 1. There is no same-cycle bypass.
- Simultaneous push and flush: the flush wins, the pushed event is lost, and `ovf` is not set.

## Timing
- Reset (async assert, sync release by the flops):
  - `q_evt`=0, `hit`=0, `count`=0, `ovf`=0.
  - All `pending`, accepted levels, synchronizers and debounce counters are 0.
  - Reset mid-operation discards all queued and pending events.
- Press latency: for a clean edge at cycle 0, the accepted level flips at cycle 2+`DEBOUNCE`, `pending` sets at that same edge, and the push occurs on the following cycle. Pending events arbitrate one per cycle.
- Load latency: 1 cycle. Address and `rden` are sampled at edge N; `q_evt` and `hit` are valid after edge N and held until the next qualifying load.
- Pop and status clear take effect at edge N. Back-to-back loads on consecutive cycles each pop one entry.

## Test plan
- Reset and empty read: after reset, with `DEBOUNCE`=4, a load of `EVT_ADDR` returns `q_evt`=0 with `hit`=1 next cycle. A load of `STAT_ADDR` returns 0.
- Single press: `btn`=4'b0100 held for 10 cycles → `count`=1 at the expected cycle (2+4+1). An `EVT_ADDR` load returns 3, then `count`=0. Releasing generates nothing.
- Bounce rejection: `btn[0]` toggles every 2 cycles for 20 cycles with `DEBOUNCE`=4 → no event. A steady hold afterwards produces exactly one code 1.
- Simultaneous presses: `btn`=4'b1011 with all edges in the same cycle → FIFO order is 1, 2, 4 on consecutive cycles. Loads return 1, 2, 4, then 0.
- Overflow: `DEPTH`=8 with 9 separate presses and no reads → `count`=8. The status load returns 0x8008, and a second status load returns 0x0008. The 8 reads return the first 8 codes in order.
- Flush and concurrency: with 3 queued events, a store to `EVT_ADDR` gives `count`=0. A push and a pop in the same cycle with `count`=2 leave `count`=2.
